// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor controller.
package serial_add_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder: parity for the sum, majority for the carry.
module fa_cell (
    input  logic Cin,
    input  logic X,
    input  logic Y,
    output logic Cout,
    output logic Sum
);

    assign Sum  = X ^ Y ^ Cin;
    assign Cout = (X & Y) | (X & Cin) | (Y & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one shared full-adder cell, LSB first,
// with Start/Done handshake and a result register held until the next operation.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Ovf
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cell_sum, cell_cout;
    logic             last_bit;
    logic             accept;

    fa_cell u_fa (
        .Cin  (carry),
        .X    (op_a[0]),
        .Y    (op_b[0]),
        .Cout (cell_cout),
        .Sum  (cell_sum)
    );

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at bit 0.
    assign acc_nxt  = {cell_sum, acc[WIDTH-1:1]};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                Busy = 1'b1;
                if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                Done = 1'b1;
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            Result <= '0;
            Cout   <= 1'b0;
            Ovf    <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
            op_a  <= A;
            op_b  <= Sub ? ~B : B;
            carry <= Sub;
            cnt   <= '0;
            acc   <= '0;
        end else if (state == ST_RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            acc   <= acc_nxt;
            carry <= cell_cout;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                // carry still holds the carry into the MSB on this edge.
                Result <= acc_nxt;
                Cout   <= cell_cout;
                Ovf    <= carry ^ cell_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         Start = 1'b0;
    logic         Sub = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Busy, Done, Cout, Ovf;
    logic [W-1:0] Result;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Sub(Sub), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .Result(Result), .Cout(Cout), .Ovf(Ovf)
    );

    always #5 Clk = ~Clk;

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        int ua, ub, sa, sb, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r  = W'(ua - ub);
            co = (ua >= ub);
            s  = sa - sb;
        end else begin
            r  = W'(ua + ub);
            co = ((ua + ub) >> W) != 0;
            s  = sa + sb;
        end
        ov = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    // Pulse Start for one edge, then wait (bounded) for Done. lat counts edges
    // from the Start edge to the Done cycle; busy counts cycles with Busy high.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output int lat, output int busy, output logic [W-1:0] r,
                         output logic co, output logic ov);
        @(negedge Clk);
        A = a; B = b; Sub = sub; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        A = ~a; B = ~b; Sub = ~sub;
        lat = 1;
        busy = 0;
        while (!Done && lat < 40) begin
            if (Busy) busy++;
            @(negedge Clk);
            lat++;
        end
        r = Result; co = Cout; ov = Ovf;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        #1;
        checks++;
        if ({Busy, Done, Result, Cout, Ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b res=%h cout=%b ovf=%b, want all 0",
                     Busy, Done, Result, Cout, Ovf);
        end
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", Busy, Done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{8'h3C, 8'hFF, 8'h7F, 8'h10, 8'h80};
        logic [W-1:0] tb [5] = '{8'h0F, 8'h01, 8'h01, 8'h20, 8'h01};
        logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] er [5] = '{8'h4B, 8'h00, 8'h80, 8'hF0, 8'h7F};
        logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat, busy;
        logic [W-1:0] r;
        logic co, ov;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], ts[i], lat, busy, r, co, ov);
            checks++;
            if (lat !== W + 1 || busy !== W) begin
                errors++;
                $display("FAIL dir%0d_timing: latency=%0d busy=%0d, want %0d %0d", i, lat, busy, W + 1, W);
            end
            checks++;
            if (r !== er[i] || co !== ec[i] || ov !== eo[i]) begin
                errors++;
                $display("FAIL dir%0d_result: got %h/%b/%b, want %h/%b/%b", i, r, co, ov, er[i], ec[i], eo[i]);
            end
            @(negedge Clk);
            checks++;
            if (Done !== 1'b0 || Result !== er[i]) begin
                errors++;
                $display("FAIL dir%0d_done_pulse: done=%b res=%h, want 0 %h", i, Done, Result, er[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, busy;
        logic [W-1:0] a, b, r, mr;
        logic s, co, ov, mc, mo;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            model(a, b, s, mr, mc, mo);
            do_op(a, b, s, lat, busy, r, co, ov);
            checks++;
            if (lat !== W + 1 || r !== mr || co !== mc || ov !== mo) begin
                errors++;
                $display("FAIL rand%0d %h%s%h: got lat=%0d %h/%b/%b, want lat=%0d %h/%b/%b",
                         i, a, s ? "-" : "+", b, lat, r, co, ov, W + 1, mr, mc, mo);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        int dones = 0;
        int first = -1;
        logic [W-1:0] got = '0;
        @(negedge Clk);
        A = 8'h3C; B = 8'h0F; Sub = 1'b0; Start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (c == 3) begin
                A = 8'h01; B = 8'h01; Start = 1'b1;
            end
            if (Done) begin
                dones++;
                if (first < 0) begin
                    first = c;
                    got = Result;
                end
            end
        end
        Start = 1'b0;
        checks++;
        if (dones !== 1 || first !== W + 1 || got !== 8'h4B) begin
            errors++;
            $display("FAIL ignore_start: dones=%0d at=%0d res=%h, want 1 at %0d res 4b", dones, first, got, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        int c = 0;
        int d1 = -1;
        int d2 = -1;
        logic [W-1:0] r2 = '0;
        @(negedge Clk);
        A = 8'h05; B = 8'h03; Sub = 1'b0; Start = 1'b1;
        @(negedge Clk);
        c = 1;
        A = 8'h0A; B = 8'h0A;
        while (d2 < 0 && c < 40) begin
            if (Done) begin
                if (d1 < 0) begin
                    d1 = c;
                    checks++;
                    if (Result !== 8'h08) begin
                        errors++;
                        $display("FAIL b2b_first: res=%h, want 08", Result);
                    end
                end else begin
                    d2 = c;
                    r2 = Result;
                end
            end else if (d1 >= 0) begin
                Start = 1'b0;
                checks++;
                if (Result !== 8'h08) begin
                    errors++;
                    $display("FAIL b2b_hold cyc%0d: res=%h, want 08", c, Result);
                end
            end
            @(negedge Clk);
            c++;
        end
        Start = 1'b0;
        checks++;
        if (d1 !== W + 1 || d2 - d1 !== W + 1 || r2 !== 8'h14) begin
            errors++;
            $display("FAIL b2b_second: d1=%0d d2=%0d res=%h, want d1=%0d gap=%0d res 14", d1, d2, r2, W + 1, W + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, busy;
        int dones = 0;
        logic [W-1:0] r;
        logic co, ov;
        do_op(8'h7F, 8'h01, 1'b0, lat, busy, r, co, ov);
        @(negedge Clk);
        A = 8'h3C; B = 8'h0F; Sub = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        #1;
        checks++;
        if ({Busy, Done, Result, Cout, Ovf} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b res=%h cout=%b ovf=%b, want all 0",
                     Busy, Done, Result, Cout, Ovf);
        end
        @(negedge Clk);
        Rst = 1'b0;
        repeat (12) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d, want 0", dones);
        end
        do_op(8'h10, 8'h20, 1'b1, lat, busy, r, co, ov);
        checks++;
        if (lat !== W + 1 || r !== 8'hF0 || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op: lat=%0d %h/%b/%b, want %0d f0/0/0", lat, r, co, ov, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
